// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg: shared mode encoding and field widths for the multi-channel counter
package multi_counter_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    UP_SAT    = 2'b10,
    ONE_SHOT  = 2'b11
  } mode_e;
endpackage

// File: rtl/multi_counter_if.sv
// multi_counter_if: control bus (en/clr/load/load_val/term_val/mode in) and status bus (count/tc/toggle/armed out), packed per channel
interface multi_counter_if #(parameter int NUM_CH = 4, parameter int WIDTH = 4);
  import multi_counter_pkg::*;
  logic [NUM_CH-1:0]        en;
  logic [NUM_CH-1:0]        clr;
  logic [NUM_CH-1:0]        load;
  logic [NUM_CH*WIDTH-1:0]  load_val;
  logic [NUM_CH*WIDTH-1:0]  term_val;
  logic [NUM_CH*MODE_W-1:0] mode;
  logic [NUM_CH*WIDTH-1:0]  count;
  logic [NUM_CH-1:0]        tc;
  logic [NUM_CH-1:0]        toggle;
  logic [NUM_CH-1:0]        armed;
  modport master (output en, clr, load, load_val, term_val, mode, input count, tc, toggle, armed);
  modport slave (input en, clr, load, load_val, term_val, mode, output count, tc, toggle, armed);
endinterface

// File: rtl/multi_counter_channel.sv
// counter_channel: one channel; inputs clock/reset_n/en/clr/load/load_val/term_val/mode, registered outputs count/tc/toggle/armed
module counter_channel
  import multi_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  mode_e            mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             toggle,
  output logic             armed
);
  logic [WIDTH-1:0] count_d, inc, dec;
  logic             armed_d, evt, at_term, at_zero;
  assign inc     = count + 1'b1;
  assign dec     = count - 1'b1;
  assign at_term = count >= term_val;
  assign at_zero = count == '0;
  always_comb begin
    count_d = count;
    armed_d = armed;
    evt     = 1'b0;
    if (clr) begin
      count_d = '0;
      armed_d = 1'b1;
    end else if (load) begin
      count_d = load_val < term_val ? load_val : term_val;
      armed_d = 1'b1;
    end else if (en) begin
      case (mode)
        UP_WRAP: begin
          count_d = at_term ? '0 : inc;
          evt     = at_term;
        end
        DOWN_WRAP: begin
          count_d = at_zero ? term_val : dec;
          evt     = at_zero;
        end
        UP_SAT: begin
          count_d = at_term ? count : inc;
          evt     = !at_term && inc == term_val;
        end
        default: begin
          count_d = !armed ? count : at_term ? '0 : inc;
          armed_d = armed && !at_term;
          evt     = armed && at_term;
        end
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      tc     <= 1'b0;
      toggle <= 1'b0;
      armed  <= 1'b1;
    end else begin
      count  <= count_d;
      armed  <= armed_d;
      tc     <= evt;
      toggle <= toggle ^ evt;
    end
  end
endmodule

// File: rtl/multi_counter.sv
// multi_counter: NUM_CH independent counter channels; clock/reset_n plain ports, per-channel controls and status on the slave bus
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  multi_counter_if.slave  bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .en       (bus.en[i]),
      .clr      (bus.clr[i]),
      .load     (bus.load[i]),
      .load_val (bus.load_val[i*WIDTH +: WIDTH]),
      .term_val (bus.term_val[i*WIDTH +: WIDTH]),
      .mode     (mode_e'(bus.mode[i*MODE_W +: MODE_W])),
      .count    (bus.count[i*WIDTH +: WIDTH]),
      .tc       (bus.tc[i]),
      .toggle   (bus.toggle[i]),
      .armed    (bus.armed[i])
    );
  end
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: scoreboard bench for multi_counter with directed vectors
module tb_multi_counter;
  import multi_counter_pkg::*;
  typedef struct {
    string      nm;
    int         ch;
    logic [3:0] c;
    logic       t;
    logic       g;
    logic       a;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  multi_counter_if #(.NUM_CH(4), .WIDTH(4)) bus ();
  multi_counter #(.NUM_CH(4), .WIDTH(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic exp(input string nm, input int ch, input int c, input int t, input int g, input int a);
    exp_t e;
    e.nm = nm;
    e.ch = ch;
    e.c  = 4'(c);
    e.t  = t[0];
    e.g  = g[0];
    e.a  = a[0];
    sb.push_back(e);
  endtask
  task automatic cfg(input int ch, input logic [1:0] m, input logic [3:0] t);
    bus.mode[ch*2 +: 2]     = m;
    bus.term_val[ch*4 +: 4] = t;
  endtask
  initial begin : monitor
    exp_t       e;
    logic [6:0] act, want;
    forever begin
      @(posedge clock or negedge reset_n);
      #1;
      while (sb.size() > 0) begin
        e    = sb.pop_front();
        act  = {bus.count[e.ch*4 +: 4], bus.tc[e.ch], bus.toggle[e.ch], bus.armed[e.ch]};
        want = {e.c, e.t, e.g, e.a};
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL %s ch%0d: got count=%0d tc=%b toggle=%b armed=%b, want count=%0d tc=%b toggle=%b armed=%b",
                   e.nm, e.ch, act[6:3], act[2], act[1], act[0], want[6:3], want[2], want[1], want[0]);
        end
      end
    end
  end
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached with %0d checks pending", sb.size());
    $fatal(1, "timeout");
  end
  initial begin : stim
    reset_n      = 1'b0;
    bus.en       = '0;
    bus.clr      = '0;
    bus.load     = '0;
    bus.load_val = '0;
    bus.term_val = 16'hFFFF;
    bus.mode     = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cfg(1, 2'b00, 4'd0);
    cfg(2, 2'b11, 4'd0);
    bus.en = 4'b0111;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      exp("up15", 0, k, 0, 0, 1);
      exp("t0_pre", 1, 0, 1, k % 2, 1);
      exp("os_pre", 2, 0, k == 1, 1, 0);
      @(negedge clock);
    end
    #2;
    reset_n = 1'b0;
    exp("async_rst", 0, 0, 0, 0, 1);
    exp("async_rst", 1, 0, 0, 0, 1);
    exp("async_rst", 2, 0, 0, 0, 1);
    @(negedge clock);
    reset_n = 1'b1;
    bus.en  = 4'b0001;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clock);
      exp("post_rst", 0, k, 0, 0, 1);
      @(negedge clock);
    end
    bus.en  = '0;
    bus.clr = 4'b0001;
    @(posedge clock);
    exp("clr", 0, 0, 0, 0, 1);
    @(negedge clock);
    bus.clr = '0;
    cfg(0, 2'b00, 4'd5);
    bus.en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      exp("wrap5", 0, k % 6, (k % 6) == 0, k >= 6 && k < 12, 1);
      @(negedge clock);
    end
    bus.en = '0;
    cfg(2, 2'b01, 4'd3);
    bus.load_val[8 +: 4] = 4'd2;
    bus.load = 4'b0100;
    @(posedge clock);
    exp("load2", 2, 2, 0, 0, 1);
    @(negedge clock);
    bus.load = '0;
    bus.en   = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock);
      exp("down3", 2, ((2 - k) % 4 + 4) % 4, (((2 - k) % 4 + 4) % 4) == 3, k >= 3 && k < 7, 1);
      @(negedge clock);
    end
    bus.en = '0;
    bus.load_val[8 +: 4] = 4'd9;
    bus.load = 4'b0100;
    @(posedge clock);
    exp("clamp", 2, 3, 0, 0, 1);
    @(negedge clock);
    bus.load = '0;
    cfg(2, 2'b01, 4'd1);
    bus.en = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      exp("down_above_t", 2, k == 4 ? 1 : 3 - k, k == 4, k == 4, 1);
      @(negedge clock);
    end
    cfg(2, 2'b00, 4'd1);
    @(posedge clock);
    exp("mode_change", 2, 0, 1, 0, 1);
    @(negedge clock);
    bus.en = '0;
    cfg(3, 2'b10, 4'd4);
    bus.en = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      exp("sat4", 3, k < 4 ? k : 4, k == 4, k >= 4, 1);
      @(negedge clock);
    end
    bus.en = '0;
    cfg(1, 2'b11, 4'd2);
    bus.en = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      exp("oneshot2", 1, k < 3 ? k : 0, k == 3, k >= 3, k < 3);
      @(negedge clock);
    end
    bus.load_val[4 +: 4] = 4'd1;
    bus.load = 4'b0010;
    @(posedge clock);
    exp("rearm", 1, 1, 0, 1, 1);
    @(negedge clock);
    bus.load = '0;
    @(posedge clock);
    exp("rearm_cnt", 1, 2, 0, 1, 1);
    @(negedge clock);
    @(posedge clock);
    exp("rearm_evt", 1, 0, 1, 0, 0);
    @(negedge clock);
    bus.en = 4'b0001;
    @(posedge clock);
    exp("prio_pre", 0, 1, 0, 0, 1);
    @(negedge clock);
    bus.clr  = 4'b0001;
    bus.load = 4'b0001;
    bus.load_val[0 +: 4] = 4'd4;
    @(posedge clock);
    exp("prio_clr", 0, 0, 0, 0, 1);
    @(negedge clock);
    bus.clr = '0;
    bus.load_val[0 +: 4] = 4'd7;
    cfg(0, 2'b00, 4'd9);
    @(posedge clock);
    exp("prio_load", 0, 7, 0, 0, 1);
    @(negedge clock);
    bus.load = '0;
    cfg(0, 2'b00, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      exp("t0_wrap", 0, 0, 1, k % 2, 1);
      @(negedge clock);
    end
    bus.en = '0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      exp("en_hold", 0, 0, 0, 1, 1);
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
